up_counter_controller: RTL and testbench



---
 rtl/up_counter_controller_if.sv | 27 ++
 rtl/up_counter_controller.sv | 81 ++++++++
 tb/tb_up_counter_controller.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/up_counter_controller_if.sv
// Request/status bundle between a requesting master and the up-counter sequencer.
// The master drives the run requests and the start-time settings. The sequencer drives the count and status.
interface up_counter_controller_if #(
   parameter int WIDTH = 3
);
   logic             start;
   logic             stop;
   logic             pause;
   logic             auto_reload;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] term_val;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tc_pulse;
   logic             done;
   logic             ready;

   modport master (
      output start, stop, pause, auto_reload, load_val, term_val,
      input  count, busy, tc_pulse, done, ready
   );

   modport slave (
      input  start, stop, pause, auto_reload, load_val, term_val,
      output count, busy, tc_pulse, done, ready
   );
endinterface

// File: rtl/up_counter_controller.sv
// Sequencer for a WIDTH-bit up-counter. It loads a start value, counts to a latched terminal value,
// and then either finishes (single-shot) or reloads the start value (auto-reload).
module up_counter_controller #(
   parameter int WIDTH = 3
) (
   input logic                    clk,
   input logic                    rst,
   up_counter_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic [WIDTH-1:0] load_reg, load_next;
   logic [WIDTH-1:0] term_reg, term_next;
   logic             auto_reg, auto_next;
   logic             busy_reg, done_reg;
   logic             tc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         count_reg <= '0;
         load_reg  <= '0;
         term_reg  <= '0;
         auto_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         load_reg  <= load_next;
         term_reg  <= term_next;
         auto_reg  <= auto_next;
         // busy and done are registered copies of the state being entered
         busy_reg  <= (state_next == RUN);
         done_reg  <= (state_next == DONE);
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      load_next  = load_reg;
      term_next  = term_reg;
      auto_next  = auto_reg;
      tc         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               load_next  = bus.load_val;
               term_next  = bus.term_val;
               auto_next  = bus.auto_reload;
               count_next = bus.load_val;
               state_next = RUN;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_next = IDLE;
            end else if (!bus.pause) begin
               if (count_reg == term_reg) begin
                  tc = 1'b1;
                  if (auto_reg) count_next = load_reg;
                  else          state_next = DONE;
               end else begin
                  count_next = count_reg + WIDTH'(1);
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign bus.count    = count_reg;
   assign bus.busy     = busy_reg;
   assign bus.done     = done_reg;
   assign bus.tc_pulse = tc;
   assign bus.ready    = (state_reg == IDLE);
endmodule

// File: tb/tb_up_counter_controller.sv
// Self-checking bench for up_counter_controller. It applies table vectors through a scoreboard queue,
// then runs hand-written multi-cycle checks for auto-reload period and single-shot run length.
module tb_up_counter_controller;
   localparam int WIDTH = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   up_counter_controller_if #(.WIDTH(WIDTH)) bus ();

   up_counter_controller #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       rst, start, stop, pause, auto_rl;
      logic [2:0] load, term;
      bit         chk;
      logic [2:0] e_count;
      logic       e_busy, e_tc, e_done, e_ready;
   } vec_t;

   typedef struct {
      bit         chk;
      logic [2:0] e_count;
      logic       e_busy, e_tc, e_done, e_ready;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic v(input logic r, s, sp, p, a, input logic [2:0] ld, tm,
                    input logic [2:0] c, input logic b, t, d, rdy, input bit ck = 1);
      vec_t x;
      x.rst = r; x.start = s; x.stop = sp; x.pause = p; x.auto_rl = a;
      x.load = ld; x.term = tm; x.chk = ck;
      x.e_count = c; x.e_busy = b; x.e_tc = t; x.e_done = d; x.e_ready = rdy;
      vecs.push_back(x);
   endtask

   initial begin
      exp_t e;
      int   tc_cnt, done_cnt, run_cnt;

      rst = 1'b1;
      bus.start = 0; bus.stop = 0; bus.pause = 0; bus.auto_reload = 0;
      bus.load_val = 0; bus.term_val = 0;

      //  rst st sp pa au ld tm    cnt bsy tc dn rdy
      v(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);
      v(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
      v(1, 1, 0, 0, 0, 5, 5,   0, 0, 0, 0, 1);
      v(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
      // single-shot 2..5; start during DONE is ignored
      v(0, 1, 0, 0, 0, 2, 5,   0, 0, 0, 0, 1);
      v(0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   5, 1, 1, 0, 0);
      v(0, 1, 0, 0, 1, 0, 0,   5, 0, 0, 1, 0);
      // wrap-around 6,7,0,1
      v(0, 1, 0, 0, 0, 6, 1,   5, 0, 0, 0, 1);
      v(0, 0, 0, 0, 0, 0, 0,   6, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   7, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0);
      // load == term: one RUN cycle
      v(0, 1, 0, 0, 0, 3, 3,   1, 0, 0, 0, 1);
      v(0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 0);
      // auto-reload 1..3 with pause, start in RUN ignored, stop on terminal
      v(0, 1, 0, 0, 1, 1, 3,   3, 0, 0, 0, 1);
      v(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0);
      v(0, 1, 0, 0, 0, 7, 7,   1, 1, 0, 0, 0);
      v(0, 0, 0, 1, 0, 0, 0,   2, 1, 0, 0, 0);
      v(0, 0, 0, 1, 0, 0, 0,   2, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
      v(0, 0, 1, 0, 0, 0, 0,   3, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 1);
      // stop at count 4 of a 2..6 run
      v(0, 1, 0, 0, 0, 2, 6,   3, 0, 0, 0, 1);
      v(0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
      v(0, 0, 1, 0, 0, 0, 0,   4, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 1);
      v(0, 0, 0, 0, 0, 0, 0,   4, 0, 0, 0, 1);
      // reset mid-run at count 5, then full 0..7 run
      v(0, 1, 0, 0, 0, 3, 6,   4, 0, 0, 0, 1);
      v(0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
      v(1, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0);
      v(0, 1, 0, 0, 0, 0, 7,   0, 0, 0, 0, 1);
      for (int i = 0; i < 7; i++)
         v(0, 0, 0, 0, 0, 0, 0, 3'(i), 1, 0, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   7, 1, 1, 0, 0);
      v(0, 0, 0, 0, 0, 0, 0,   7, 0, 0, 1, 0);
      v(0, 0, 0, 0, 0, 0, 0,   7, 0, 0, 0, 1);

      #1;
      foreach (vecs[i]) begin
         rst       = vecs[i].rst;
         bus.start = vecs[i].start;
         bus.stop  = vecs[i].stop;
         bus.pause = vecs[i].pause;
         if (vecs[i].start) begin
            bus.auto_reload = vecs[i].auto_rl;
            bus.load_val    = vecs[i].load;
            bus.term_val    = vecs[i].term;
         end else begin
            // settings presented without start must never matter
            bus.auto_reload = 1'($urandom_range(1));
            bus.load_val    = 3'($urandom_range(7));
            bus.term_val    = 3'($urandom_range(7));
         end
         e.chk = vecs[i].chk; e.e_count = vecs[i].e_count; e.e_busy = vecs[i].e_busy;
         e.e_tc = vecs[i].e_tc; e.e_done = vecs[i].e_done; e.e_ready = vecs[i].e_ready;
         exp_q.push_back(e);
         #2;
         e = exp_q.pop_front();
         if (e.chk) begin
            check($sformatf("v%0d count", i), int'(bus.count), int'(e.e_count));
            check($sformatf("v%0d busy", i), int'(bus.busy), int'(e.e_busy));
            check($sformatf("v%0d tc_pulse", i), int'(bus.tc_pulse), int'(e.e_tc));
            check($sformatf("v%0d done", i), int'(bus.done), int'(e.e_done));
            check($sformatf("v%0d ready", i), int'(bus.ready), int'(e.e_ready));
         end
         $display("vec %0d rst=%0b start=%0b stop=%0b pause=%0b count=%0d busy=%0b tc=%0b done=%0b ready=%0b",
                  i, rst, bus.start, bus.stop, bus.pause, bus.count, bus.busy, bus.tc_pulse, bus.done, bus.ready);
         @(posedge clk); #1;
      end

      // auto-reload 5..4 wraps through 0: period 8, three strobes in 24 cycles, never done
      rst = 0; bus.stop = 0; bus.pause = 0;
      bus.start = 1; bus.auto_reload = 1; bus.load_val = 5; bus.term_val = 4;
      @(posedge clk); #1;
      bus.start = 0;
      tc_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         if (bus.tc_pulse) begin
            tc_cnt++;
            check("auto tc position", i % 8, 7);
            check("auto tc count value", int'(bus.count), 4);
         end
         if (bus.done) done_cnt++;
         @(posedge clk); #1;
      end
      check("auto tc total", tc_cnt, 3);
      check("auto done never", done_cnt, 0);
      $display("auto-reload window tc=%0d done=%0d", tc_cnt, done_cnt);
      bus.stop = 1;
      @(posedge clk); #1;
      bus.stop = 0;
      check("auto stop ready", int'(bus.ready), 1);
      check("auto stop busy", int'(bus.busy), 0);

      // single-shot 7..0 wraps: two RUN cycles, one strobe, one done
      bus.start = 1; bus.auto_reload = 0; bus.load_val = 7; bus.term_val = 0;
      @(posedge clk); #1;
      bus.start = 0;
      run_cnt = 0; tc_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.busy) run_cnt++;
         if (bus.tc_pulse) tc_cnt++;
         if (bus.done) done_cnt++;
         @(posedge clk); #1;
      end
      check("single run length", run_cnt, 2);
      check("single tc total", tc_cnt, 1);
      check("single done total", done_cnt, 1);
      check("single final count", int'(bus.count), 0);
      $display("single-shot run=%0d tc=%0d done=%0d", run_cnt, tc_cnt, done_cnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
